video_ports_rd: RTL

VIDEO_PORTS_RD -- requirements
Module: video_ports_rd

---
 rtl/video_ports_rd_pkg.sv | 51 +++++
 rtl/video_ports_rd_strobe_edge.sv | 25 ++
 rtl/video_ports_rd.sv | 108 ++++++++++
 3 files changed

// File: rtl/video_ports_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_ports_rd_pkg
// Description : Shared video constants: status bit map, strobe indices and
//               the read-port priority select.
// Revision    : 1.0
// ============================================================================
package video_ports_rd_pkg;

    localparam int STAT_FRAME_BIT  = 0;
    localparam int STAT_LINE_BIT   = 1;
    localparam int STAT_VBLANK_BIT = 2;
    localparam int STAT_OVR_BIT    = 6;

    localparam int NUM_STROBES = 4;
    localparam int STB_STATUS  = 0;
    localparam int STB_VLINE_L = 1;
    localparam int STB_VLINE_H = 2;
    localparam int STB_FCNT    = 3;

    typedef enum logic [2:0] {
        SEL_NONE    = 3'd0,
        SEL_STATUS  = 3'd1,
        SEL_VLINE_L = 3'd2,
        SEL_VLINE_H = 3'd3,
        SEL_FCNT    = 3'd4
    } port_sel_t;

    function automatic port_sel_t select_port(input logic [NUM_STROBES-1:0] edges);
        port_sel_t sel;
        sel = SEL_NONE;
        if (edges[STB_STATUS])       sel = SEL_STATUS;
        else if (edges[STB_VLINE_L]) sel = SEL_VLINE_L;
        else if (edges[STB_VLINE_H]) sel = SEL_VLINE_H;
        else if (edges[STB_FCNT])    sel = SEL_FCNT;
        return sel;
    endfunction

    function automatic logic [7:0] status_byte(input logic frame_p, input logic line_p,
                                               input logic vblank, input logic ovr);
        logic [7:0] b;
        b                  = 8'h00;
        b[STAT_FRAME_BIT]  = frame_p;
        b[STAT_LINE_BIT]   = line_p;
        b[STAT_VBLANK_BIT] = vblank;
        b[STAT_OVR_BIT]    = ovr;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_ports_rd_strobe_edge.sv
`default_nettype none
// ============================================================================
// Module      : strobe_edge
// Description : Rising-edge detector for one level read strobe.
// Revision    : 1.0
// ============================================================================
module strobe_edge (
    input  logic clk,
    input  logic res_n,
    input  logic strobe,
    output logic rise
);

    logic r_prev;

    // History resets to 0 so a strobe already high at reset release fires once.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) r_prev <= 1'b0;
        else        r_prev <= strobe;
    end

    assign rise = strobe & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/video_ports_rd.sv
`default_nettype none
// ============================================================================
// Module      : video_ports_rd
// Description : Z80 read ports for video status, line counter and frame count.
// Revision    : 1.0
// ============================================================================
module video_ports_rd
    import video_ports_rd_pkg::*;
(
    input  logic       clk,
    input  logic       res_n,
    input  logic       status_rd,
    input  logic       vline_l_rd,
    input  logic       vline_h_rd,
    input  logic       fcnt_rd,
    input  logic [8:0] vcnt,
    input  logic       vblank,
    input  logic       int_start,
    input  logic       line_int,
    output logic [7:0] dout,
    output logic       dout_vld
);

    logic [NUM_STROBES-1:0] w_strobes;
    logic [NUM_STROBES-1:0] w_edges;
    port_sel_t              w_sel;
    logic                   w_clr;

    logic [7:0] r_dout;
    logic       r_dout_vld;
    logic       r_frame_p;
    logic       r_line_p;
    logic       r_ovr;
    logic [8:0] r_snap;
    logic       r_snap_vld;
    logic [7:0] r_fcnt;

    assign w_strobes[STB_STATUS]  = status_rd;
    assign w_strobes[STB_VLINE_L] = vline_l_rd;
    assign w_strobes[STB_VLINE_H] = vline_h_rd;
    assign w_strobes[STB_FCNT]    = fcnt_rd;

    generate
        for (genvar gi = 0; gi < NUM_STROBES; gi++) begin : g_edge
            strobe_edge u_edge (
                .clk    (clk),
                .res_n  (res_n),
                .strobe (w_strobes[gi]),
                .rise   (w_edges[gi])
            );
        end
    endgenerate

    assign w_sel = select_port(w_edges);
    assign w_clr = (w_sel == SEL_STATUS);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_dout     <= 8'h00;
            r_dout_vld <= 1'b0;
            r_frame_p  <= 1'b0;
            r_line_p   <= 1'b0;
            r_ovr      <= 1'b0;
            r_snap     <= 9'h000;
            r_snap_vld <= 1'b0;
            r_fcnt     <= 8'h00;
        end else begin
            r_dout_vld <= 1'b0;
            // Events OR in after the read clear, so a coincident event survives.
            r_frame_p  <= (r_frame_p & ~w_clr) | int_start;
            r_line_p   <= (r_line_p  & ~w_clr) | line_int;
            r_ovr      <= (r_ovr     & ~w_clr) | (int_start & r_frame_p);
            if (int_start) r_fcnt <= r_fcnt + 8'd1;

            case (w_sel)
                SEL_STATUS: begin
                    r_dout     <= status_byte(r_frame_p, r_line_p, vblank, r_ovr);
                    r_dout_vld <= 1'b1;
                end
                SEL_VLINE_L: begin
                    r_dout     <= vcnt[7:0];
                    r_snap     <= vcnt;
                    r_snap_vld <= 1'b1;
                    r_dout_vld <= 1'b1;
                end
                SEL_VLINE_H: begin
                    if (r_snap_vld) begin
                        r_dout     <= {1'b1, 6'b000000, r_snap[8]};
                        r_snap_vld <= 1'b0;
                    end else begin
                        r_dout     <= {7'b0000000, vcnt[8]};
                    end
                    r_dout_vld <= 1'b1;
                end
                SEL_FCNT: begin
                    r_dout     <= r_fcnt;
                    r_dout_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;

endmodule
`default_nettype wire
